// File: rtl/divider.sv
// Sequential signed 32-bit divider for the HI/LO register pair.
// Restoring shift-subtract over operand magnitudes: one accept cycle, 32
// iteration cycles (CALC) and one sign-fixup/writeback cycle (FIX).
// LO receives the quotient (truncated toward zero), HI the remainder
// (sign of the dividend). A zero divisor raises a one-cycle DivZero pulse
// and leaves HI/LO untouched.
//
// Handshake: DivCtrl is a start request that is only looked at while the
// FSM is IDLE (Busy low); a request seen while Busy is dropped, not queued.
// Operands are captured on the accepting edge and may change afterwards.
// DivDone pulses for exactly one cycle once HI/LO hold the new result, and
// the divider is already IDLE in that cycle, so a new request is accepted.
module divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        DivCtrl,
  input  logic [31:0] dividendo,
  input  logic [31:0] divisor,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        DivDone,
  output logic        DivZero,
  output logic        Busy,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [32:0] r_q, r_d;        // partial remainder
  logic [31:0] q_q, q_d;        // dividend magnitude shifting into quotient
  logic [31:0] m_q, m_d;        // divisor magnitude
  logic [5:0]  cnt_q, cnt_d;    // iteration count
  logic        qneg_q, qneg_d;  // quotient must be negated
  logic        rneg_q, rneg_d;  // remainder must be negated
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        zero_q, zero_d;

  // Magnitudes; 0x80000000 maps to itself, which is correct as unsigned.
  logic [31:0] abs_dividend;
  logic [31:0] abs_divisor;
  // {R,Q} shifted left by one, viewed as a 34-bit quantity so the trial
  // subtraction's borrow lands in the top bit.
  logic [33:0] shifted;
  logic [33:0] trial;

  assign abs_dividend = dividendo[31] ? (~dividendo + 32'd1) : dividendo;
  assign abs_divisor  = divisor[31]   ? (~divisor + 32'd1)   : divisor;
  assign shifted      = {r_q, q_q[31]};
  assign trial        = shifted - {2'b00, m_q};

  // Next-state, datapath and output pulses.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    zero_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DivCtrl) begin
          if (divisor == 32'd0) begin
            zero_d = 1'b1;
          end else begin
            q_d     = abs_dividend;
            m_d     = abs_divisor;
            qneg_d  = dividendo[31] ^ divisor[31];
            rneg_d  = dividendo[31];
            r_d     = 33'd0;
            cnt_d   = 6'd0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!trial[33]) begin
          r_d = trial[32:0];
          q_d = {q_q[30:0], 1'b1};
        end else begin
          r_d = shifted[32:0];
          q_d = {q_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        lo_d    = qneg_q ? (~q_q + 32'd1) : q_q;
        hi_d    = rneg_q ? (~r_q[31:0] + 32'd1) : r_q[31:0];
        done_d  = 1'b1;
        cnt_d   = 6'd0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q    <= 33'd0;
      q_q    <= 32'd0;
      m_q    <= 32'd0;
      cnt_q  <= 6'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      m_q    <= m_d;
      cnt_q  <= cnt_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      zero_q <= zero_d;
    end
  end

  assign HI          = hi_q;
  assign LO          = lo_q;
  assign DivDone     = done_q;
  assign DivZero     = zero_q;
  assign Busy        = (state_q == S_CALC) || (state_q == S_FIX);
  assign dbg_state_o = state_q;

endmodule
